// File: rtl/pool_frame_buffer_pkg.sv
// pool_frame_buffer_pkg: shared geometry constants and read-FSM encodings for the pooled frame buffer
package pool_frame_buffer_pkg;
  localparam int PP = 8;
  localparam int DIM = 28;
  localparam int POOL = 2;
  localparam int OUT_DIM = DIM / POOL;
  localparam int N = OUT_DIM * OUT_DIM;
  localparam int AW = $clog2(N);
  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_STREAM} rd_state_t;
endpackage

// File: rtl/pfb_bank_ram.sv
// pfb_bank_ram: two-bank simple dual-port RAM addressed by {bank, idx}, one write port, registered read port
module pfb_bank_ram
  import pool_frame_buffer_pkg::*;
#(
  parameter int W = PP + 1,
  parameter int IW = AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW:0]   waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [IW:0]   raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**(IW+1)];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pool_frame_buffer.sv
// pool_frame_buffer: captures pooled samples into ping-pong banks and replays each full frame as a valid/ready stream
module pool_frame_buffer
  import pool_frame_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [PP:0]   in_data,
  input  logic          in_valid,
  output logic [PP:0]   out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          frame_done,
  output logic          overflow
);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  rd_state_t state, state_n;
  logic wbank, rbank, wr_en, wr_last, hs, rel, re, load, adv;
  logic [1:0] bank_full;
  logic [AW-1:0] wr_idx, ra;
  logic [PP:0] rdata;
  assign wr_en = in_valid && !bank_full[wbank];
  assign wr_last = wr_en && wr_idx == LAST;
  assign hs = state == RD_STREAM && out_valid && out_ready;
  assign rel = hs && out_last;
  pfb_bank_ram #(.W(PP + 1), .IW(AW)) ram (
    .clk(clk),
    .we(wr_en),
    .waddr({wbank, wr_idx}),
    .wdata(in_data),
    .re(re),
    .raddr({rbank, ra}),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      wr_idx <= '0;
      bank_full <= 2'b00;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      frame_done <= wr_last;
      if (in_valid && bank_full[wbank]) overflow <= 1'b1;
      if (wr_en) wr_idx <= wr_last ? '0 : wr_idx + AW'(1);
      if (wr_last) wbank <= !wbank;
      if (rel) rbank <= !rbank;
      bank_full <= (bank_full & ~(rel ? 2'b01 << rbank : 2'b00)) | (wr_last ? 2'b01 << wbank : 2'b00);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) state <= RD_IDLE;
    else state <= state_n;
  end
  // rdata always holds the word after out_idx, so a handshake advances with no bubble
  always_comb begin
    state_n = state;
    re = 1'b0;
    ra = '0;
    load = 1'b0;
    adv = 1'b0;
    case (state)
      RD_IDLE: if (bank_full[rbank]) begin
        re = 1'b1;
        state_n = RD_LOAD;
      end
      RD_LOAD: begin
        load = 1'b1;
        re = 1'b1;
        ra = AW'(1);
        state_n = RD_STREAM;
      end
      RD_STREAM: if (hs) begin
        adv = !out_last;
        re = out_idx < AW'(N - 2);
        ra = out_idx + AW'(2);
        state_n = out_last ? RD_IDLE : RD_STREAM;
      end
      default: state_n = RD_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data <= '0;
      out_idx <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else if (load) begin
      out_data <= rdata;
      out_idx <= '0;
      out_valid <= 1'b1;
      out_last <= N == 1;
    end else if (adv) begin
      out_data <= rdata;
      out_idx <= out_idx + AW'(1);
      out_last <= out_idx == AW'(N - 2);
    end else if (rel) begin
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pool_frame_buffer.sv
// tb_pool_frame_buffer: random frames through a two-frame buffer model, words checked by a decoupled scoreboard monitor
module tb_pool_frame_buffer;
  import pool_frame_buffer_pkg::*;
  typedef struct packed {logic [PP:0] d; logic [AW-1:0] i; logic l;} word_t;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic out_valid, out_last, frame_done, overflow;
  logic [PP:0] in_data = '0, out_data;
  logic [AW-1:0] out_idx;
  int compared = 0, mismatched = 0, released = 0, completed = 0, comp_base = 0;
  int fd_cnt = 0, fd_base = 0, cyc_n = 0, rel_edge = -1, wr_edge = 0, rmode = 0;
  logic man_ready = 0, tog = 0, dropped = 0, prev_stall = 0;
  word_t prev_w;
  word_t exp_q[$];
  logic [PP:0] part[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  pool_frame_buffer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_done(frame_done), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    tog = ~tog;
    out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? tog : rmode == 2 ? 1'($urandom_range(0, 1)) : man_ready;
  end

  // scoreboard monitor: one handshake pops one expected word; a stalled word must hold
  initial forever begin
    word_t w;
    @(negedge clk);
    if (frame_done) fd_cnt++;
    if (reset) begin
      if (prev_stall) chk("stall_hold", 32'({out_valid, out_data, out_idx, out_last}), 32'({1'b1, prev_w}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", 32'(out_idx), 32'hFFFF_FFFF);
        else begin
          w = exp_q.pop_front();
          chk("word", 32'({out_data, out_idx, out_last}), 32'(w));
          if (w.l) begin
            released++;
            rel_edge = cyc_n + 1;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_w = {out_data, out_idx, out_last};
    end else prev_stall = 0;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // reference: two frame slots; a sample is lost only while both hold unreleased frames
  task automatic send(input logic [PP:0] d);
    word_t w;
    in_valid = 1;
    in_data = d;
    if (completed - released >= 2) dropped = 1;
    else begin
      part.push_back(d);
      if (part.size() == N) begin
        for (int i = 0; i < N; i++) begin
          w = {part[i], AW'(i), i == N - 1};
          exp_q.push_back(w);
        end
        part.delete();
        completed++;
      end
    end
    cyc();
    in_valid = 0;
    in_data = (PP + 1)'($urandom);
  endtask

  task automatic idle();
    in_valid = 0;
    in_data = (PP + 1)'($urandom);
    cyc();
  endtask

  task automatic send_frame(input bit ramp, input int gap);
    for (int i = 0; i < N; i++) begin
      send(ramp ? (PP + 1)'(i - 98) : (PP + 1)'($urandom));
      repeat (gap) idle();
    end
  endtask

  task automatic rst_dut();
    reset = 0;
    in_valid = 0;
    cyc();
    reset = 1;
    exp_q.delete();
    part.delete();
    completed = released;
    comp_base = completed;
    dropped = 0;
    fd_base = fd_cnt;
    chk("reset_state", 32'({out_valid, out_last, frame_done, overflow, out_data, out_idx}), 32'(0));
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 2000) begin
      cyc();
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (4) cyc();
    chk("idle_after", 32'(out_valid), 32'(0));
    chk("frame_done_count", fd_cnt - fd_base, completed - comp_base);
    chk("overflow", 32'(overflow), 32'(dropped));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) cyc();
    rst_dut();
    rmode = 0;
    send_frame(1, 0);
    chk("frame_done_pulse", 32'(frame_done), 32'(1));
    chk("latency_0", 32'(out_valid), 32'(0));
    cyc();
    chk("latency_1", 32'(out_valid), 32'(0));
    cyc();
    chk("latency_2", 32'(out_valid), 32'(1));
    drain();
    chk("single_frame_done", fd_cnt - fd_base, 1);

    rst_dut();
    rmode = 1;
    send_frame(1, 0);
    drain();

    rst_dut();
    rmode = 3;
    man_ready = 0;
    send_frame(0, 0);
    send_frame(0, 0);
    man_ready = 1;
    send_frame(0, 0);
    chk("overflow_three_frames", 32'(overflow), 32'(1));
    drain();

    rst_dut();
    rmode = 3;
    man_ready = 0;
    send_frame(0, 0);
    repeat (3) idle();
    man_ready = 1;
    send_frame(0, 0);
    wr_edge = cyc_n;
    send((PP + 1)'($urandom));
    chk("release_coincides_write", rel_edge, wr_edge);
    chk("overflow_coincide", 32'(overflow), 32'(0));
    drain();

    rst_dut();
    rmode = 0;
    send_frame(0, 0);
    for (int i = 0; i < 100; i++) send((PP + 1)'($urandom));
    rst_dut();
    send_frame(0, 0);
    drain();

    rst_dut();
    rmode = 2;
    send_frame(0, 3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
